adding_machine_datapath: RTL and testbench

Datapath driven by the adding-machine controller. It holds the program counter, instruction buffer, instruction register, accumulator, carry flag and a unified program/data memory. It acts on the controller's strobes each cycle and returns the current opcode to it. A side-band program-load port lets a bench or boot block fill memory before execution starts.

---
 rtl/adding_machine_datapath_if.sv | 41 ++++
 rtl/adding_machine_datapath.sv | 111 +++++++++++
 tb/tb_adding_machine_datapath.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adding_machine_datapath_if.sv
// Controller <-> datapath strobe/status bundle plus the side-band program-load port.
// master = controller or bench driving strobes; slave = the datapath.
interface adding_machine_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 3
);
    logic              load_IR;
    logic              load_acc;
    logic              ld_pc;
    logic              clr_pc;
    logic              inc_pc;
    logic              sel_alu;
    logic              sel_bus;
    logic              pass_add;
    logic              ir_on_adr;
    logic              pc_on_adr;
    logic              mem_read;
    logic              mem_write;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] acc_out;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] ir_out;
    logic [ADDR_W-1:0] adr_out;
    logic              carry;

    modport master (
        output load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu, sel_bus, pass_add,
               ir_on_adr, pc_on_adr, mem_read, mem_write, prog_we, prog_addr, prog_data,
        input  opcode, acc_out, pc_out, ir_out, adr_out, carry
    );

    modport slave (
        input  load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu, sel_bus, pass_add,
               ir_on_adr, pc_on_adr, mem_read, mem_write, prog_we, prog_addr, prog_data,
        output opcode, acc_out, pc_out, ir_out, adr_out, carry
    );
endinterface

// File: rtl/adding_machine_datapath.sv
// Adding-machine datapath: PC, IB, IR, accumulator/carry and unified memory acting on controller strobes.
// Every register updates one edge after its strobe, memory reads are combinational; no backpressure, strobes act every cycle.
module adding_machine_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    adding_machine_datapath_if.slave  dp
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ib_q, ib_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] bus;
    logic [DATA_W:0]   sum;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // With no address strobe the IR operand stays on the bus, same as ir_on_adr.
    always_comb begin
        if (dp.pc_on_adr) begin
            adr = pc_q;
        end else if (dp.ir_on_adr) begin
            adr = ir_q[ADDR_W-1:0];
        end else begin
            adr = ir_q[ADDR_W-1:0];
        end
        bus = mem_q[adr];
        sum = {1'b0, acc_q} + {1'b0, bus};
    end

    always_comb begin
        pc_d = pc_q;
        if (dp.clr_pc) begin
            pc_d = '0;
        end else if (dp.inc_pc) begin
            pc_d = pc_q + ADDR_W'(1);
        end else if (dp.ld_pc) begin
            pc_d = ir_q[ADDR_W-1:0];
        end

        ib_d = dp.pc_on_adr ? bus : ib_q;
        ir_d = dp.load_IR ? ib_q : ir_q;

        acc_d   = acc_q;
        carry_d = carry_q;
        if (dp.load_acc) begin
            if (dp.sel_bus) begin
                if (dp.mem_read) begin
                    acc_d = bus;
                end
            end else if (dp.sel_alu && dp.pass_add) begin
                {carry_d, acc_d} = sum;
            end
        end
    end

    // Program load beats a datapath store; nothing is written while in reset.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = adr;
        mem_wd = acc_q;
        if (!reset) begin
            if (dp.prog_we) begin
                mem_we = 1'b1;
                mem_wa = dp.prog_addr;
                mem_wd = dp.prog_data;
            end else if (dp.mem_write) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            ib_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ib_q    <= ib_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign dp.opcode  = ir_q[DATA_W-1 -: OPC_W];
    assign dp.acc_out = acc_q;
    assign dp.pc_out  = pc_q;
    assign dp.ir_out  = ir_q;
    assign dp.adr_out = adr;
    assign dp.carry   = carry_q;
endmodule

// File: tb/tb_adding_machine_datapath.sv
// Bench for adding_machine_datapath: directed controller sequences plus random strobes,
// scored against an arithmetic model through an expectation queue.
module tb_adding_machine_datapath;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int OPC_W  = 3;
    localparam int DEPTH  = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    adding_machine_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dp_if ();

    adding_machine_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dut (
        .clock (clock),
        .reset (reset),
        .dp    (dp_if)
    );

    typedef struct packed {
        logic              load_ir;
        logic              load_acc;
        logic              ld_pc;
        logic              clr_pc;
        logic              inc_pc;
        logic              sel_alu;
        logic              sel_bus;
        logic              pass_add;
        logic              ir_on_adr;
        logic              pc_on_adr;
        logic              mem_read;
        logic              mem_write;
        logic              prog_we;
        logic [ADDR_W-1:0] prog_addr;
        logic [DATA_W-1:0] prog_data;
    } stim_t;

    typedef struct {
        int pc;
        int ir;
        int acc;
        int carry;
        int opc;
        int adr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_pc = 0, m_ib = 0, m_ir = 0, m_acc = 0, m_carry = 0;
    int m_mem [DEPTH];

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("pc_out",  int'(dp_if.pc_out),  mon_e.pc);
            chk("ir_out",  int'(dp_if.ir_out),  mon_e.ir);
            chk("acc_out", int'(dp_if.acc_out), mon_e.acc);
            chk("carry",   int'(dp_if.carry),   mon_e.carry);
            chk("opcode",  int'(dp_if.opcode),  mon_e.opc);
            chk("adr_out", int'(dp_if.adr_out), mon_e.adr);
        end
    end

    // Machine behaviour in plain integer arithmetic, evaluated on pre-edge values.
    task automatic model_step(input stim_t s, input logic rst);
        int adr, bus, sum;
        int n_pc, n_ib, n_ir, n_acc, n_carry;
        exp_t e;
        if (rst) begin
            n_pc = 0; n_ib = 0; n_ir = 0; n_acc = 0; n_carry = 0;
        end else begin
            adr  = s.pc_on_adr ? m_pc : (m_ir % DEPTH);
            bus  = m_mem[adr];
            n_ib = s.pc_on_adr ? bus : m_ib;
            n_ir = s.load_ir ? m_ib : m_ir;
            if (s.clr_pc)      n_pc = 0;
            else if (s.inc_pc) n_pc = (m_pc + 1) % DEPTH;
            else if (s.ld_pc)  n_pc = m_ir % DEPTH;
            else               n_pc = m_pc;
            n_acc   = m_acc;
            n_carry = m_carry;
            if (s.load_acc) begin
                if (s.sel_bus) begin
                    if (s.mem_read) n_acc = bus;
                end else if (s.sel_alu && s.pass_add) begin
                    sum     = m_acc + bus;
                    n_carry = sum / 256;
                    n_acc   = sum % 256;
                end
            end
            if (s.prog_we)        m_mem[int'(s.prog_addr)] = int'(s.prog_data);
            else if (s.mem_write) m_mem[adr] = m_acc;
        end
        m_pc = n_pc; m_ib = n_ib; m_ir = n_ir; m_acc = n_acc; m_carry = n_carry;
        e.pc    = m_pc;
        e.ir    = m_ir;
        e.acc   = m_acc;
        e.carry = m_carry;
        e.opc   = m_ir / 32;
        e.adr   = s.pc_on_adr ? m_pc : (m_ir % DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic drive(input stim_t s, input logic rst);
        dp_if.load_IR   = s.load_ir;
        dp_if.load_acc  = s.load_acc;
        dp_if.ld_pc     = s.ld_pc;
        dp_if.clr_pc    = s.clr_pc;
        dp_if.inc_pc    = s.inc_pc;
        dp_if.sel_alu   = s.sel_alu;
        dp_if.sel_bus   = s.sel_bus;
        dp_if.pass_add  = s.pass_add;
        dp_if.ir_on_adr = s.ir_on_adr;
        dp_if.pc_on_adr = s.pc_on_adr;
        dp_if.mem_read  = s.mem_read;
        dp_if.mem_write = s.mem_write;
        dp_if.prog_we   = s.prog_we;
        dp_if.prog_addr = s.prog_addr;
        dp_if.prog_data = s.prog_data;
        reset           = rst;
    endtask

    // Inputs change just after a falling edge and hold through the next rising edge.
    task automatic cycle(input stim_t s, input logic rst);
        drive(s, rst);
        @(posedge clock);
        model_step(s, rst);
        @(negedge clock);
        #1;
    endtask

    function automatic stim_t s_idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t s_fetch();
        stim_t s = '0;
        s.pc_on_adr = 1'b1; s.inc_pc = 1'b1; s.ld_pc = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_decode();
        stim_t s = '0;
        s.load_ir = 1'b1; s.ir_on_adr = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_exec_load();
        stim_t s = '0;
        s.load_acc = 1'b1; s.sel_bus = 1'b1; s.mem_read = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_exec_add();
        stim_t s = '0;
        s.load_acc = 1'b1; s.sel_alu = 1'b1; s.pass_add = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_exec_store();
        stim_t s = '0;
        s.mem_write = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_prog(input int a, input int d);
        stim_t s = '0;
        s.prog_we   = 1'b1;
        s.prog_addr = ADDR_W'(a);
        s.prog_data = DATA_W'(d);
        return s;
    endfunction

    function automatic stim_t rand_stim();
        logic [31:0] r;
        stim_t       s;
        r = $urandom();
        s = r[$bits(stim_t)-1:0];
        s.prog_we = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    task automatic run_instr(input stim_t exec_s);
        cycle(s_fetch(), 1'b0);
        cycle(s_decode(), 1'b0);
        cycle(exec_s, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        drive(s_idle(), 1'b1);
        @(negedge clock);
        #1;
        cycle(s_idle(), 1'b1);
        cycle(s_idle(), 1'b1);

        // Full preload so every memory word is known to the model.
        for (int a = 0; a < DEPTH; a++) begin
            cycle(s_prog(a, (a == 5) ? 8'h77 : int'($urandom_range(0, 255))), 1'b0);
        end

        // Random state without memory writes, then reset.
        for (int i = 0; i < 20; i++) begin
            s = rand_stim();
            s.prog_we   = 1'b0;
            s.mem_write = 1'b0;
            cycle(s, 1'b0);
        end
        cycle(s_idle(), 1'b1);
        cycle(s_idle(), 1'b1);
        chk("rst_pc",     int'(dp_if.pc_out),  0);
        chk("rst_ir",     int'(dp_if.ir_out),  0);
        chk("rst_acc",    int'(dp_if.acc_out), 0);
        chk("rst_carry",  int'(dp_if.carry),   0);
        chk("rst_opcode", int'(dp_if.opcode),  0);
        chk("rst_adr",    int'(dp_if.adr_out), 0);
        cycle(s_prog(0, 8'h25), 1'b0);
        run_instr(s_exec_load());
        chk("mem5_kept", int'(dp_if.acc_out), 8'h77);

        // LOAD 10 / ADD 11 / STORE 12 / LOAD 10 / LOAD 12.
        cycle(s_prog(0, 8'h2A), 1'b0);
        cycle(s_prog(1, 8'h0B), 1'b0);
        cycle(s_prog(2, 8'h4C), 1'b0);
        cycle(s_prog(3, 8'h2A), 1'b0);
        cycle(s_prog(4, 8'h2C), 1'b0);
        cycle(s_prog(10, 8'h05), 1'b0);
        cycle(s_prog(11, 8'hFE), 1'b0);
        cycle(s_prog(12, 8'h00), 1'b0);
        cycle(s_idle(), 1'b1);
        run_instr(s_exec_load());
        chk("load_pc",     int'(dp_if.pc_out),  1);
        chk("load_ir",     int'(dp_if.ir_out),  8'h2A);
        chk("load_opcode", int'(dp_if.opcode),  1);
        chk("load_acc",    int'(dp_if.acc_out), 8'h05);
        run_instr(s_exec_add());
        chk("add_acc",   int'(dp_if.acc_out), 8'h03);
        chk("add_carry", int'(dp_if.carry),   1);
        chk("add_pc",    int'(dp_if.pc_out),  2);
        run_instr(s_exec_store());
        run_instr(s_exec_load());
        chk("reload_acc", int'(dp_if.acc_out), 8'h05);
        run_instr(s_exec_load());
        chk("store_readback", int'(dp_if.acc_out), 8'h03);

        // PC corners.
        cycle(s_idle(), 1'b1);
        s = s_idle();
        s.inc_pc = 1'b1;
        for (int i = 0; i < 31; i++) cycle(s, 1'b0);
        chk("pc_at_31", int'(dp_if.pc_out), 31);
        cycle(s, 1'b0);
        chk("pc_wrap", int'(dp_if.pc_out), 0);
        cycle(s, 1'b0);
        s.clr_pc = 1'b1;
        cycle(s, 1'b0);
        chk("pc_clr_over_inc", int'(dp_if.pc_out), 0);
        cycle(s_idle(), 1'b1);
        cycle(s_fetch(), 1'b0);
        cycle(s_decode(), 1'b0);
        s = s_idle();
        s.ld_pc = 1'b1;
        cycle(s, 1'b0);
        chk("pc_jump", int'(dp_if.pc_out), 10);
        cycle(s_exec_load(), 1'b0);
        s = s_prog(10, 8'h5A);
        s.mem_write = 1'b1;
        cycle(s, 1'b0);
        cycle(s_exec_load(), 1'b0);
        chk("prog_over_store", int'(dp_if.acc_out), 8'h5A);

        // Reset landing on an ADD execute.
        cycle(s_idle(), 1'b1);
        run_instr(s_exec_load());
        cycle(s_fetch(), 1'b0);
        cycle(s_decode(), 1'b0);
        cycle(s_exec_add(), 1'b1);
        chk("rst_add_acc",   int'(dp_if.acc_out), 0);
        chk("rst_add_carry", int'(dp_if.carry),   0);
        chk("rst_add_pc",    int'(dp_if.pc_out),  0);

        // Random strobes with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(rand_stim(), ($urandom_range(0, 24) == 0));
        end

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clock);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
